// File: rtl/apb_spi_pkg.sv
// Shared constants and FSM state encoding for the APB-to-SPI flash controller.
package apb_spi_pkg;
    localparam int APB_DW = 32;

    localparam logic [7:0] CMD_READ      = 8'h01;
    localparam logic [7:0] CMD_PROG      = 8'h02;
    localparam logic [7:0] CMD_FAST_READ = 8'h0B;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_CMD   = 3'd2,
        ST_ADDR  = 3'd3,
        ST_DUMMY = 3'd4,
        ST_DATA  = 3'd5,
        ST_HOLD  = 3'd6,
        ST_DONE  = 3'd7
    } state_e;
endpackage

// File: rtl/spi_shifter.sv
// SPI mode-0 engine: clock divider, MSB-first symbol shift-out, shift-in and symbol counting.
module spi_shifter #(
    parameter int FRAME_W = 64,
    parameter int SPI_W   = 8,
    parameter int CLK_DIV = 2,
    parameter int RX_W    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               en_i,
    input  logic               shift_i,
    input  logic [FRAME_W-1:0] frame_i,
    input  logic [SPI_W-1:0]   miso_i,
    output logic               tick_o,
    output logic               sym_done_o,
    output logic [7:0]         cnt_o,
    output logic [SPI_W-1:0]   mosi_o,
    output logic               sclk_o,
    output logic [RX_W-1:0]    rx_o
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0]   div_q, div_d;
    logic               half_q, half_d;
    logic [FRAME_W-1:0] sh_q, sh_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [RX_W-1:0]    rx_q, rx_d;

    assign tick_o     = en_i && (div_q == DIV_W'(CLK_DIV - 1));
    assign sym_done_o = shift_i && tick_o && half_q;
    assign cnt_o      = cnt_q;
    assign mosi_o     = shift_i ? sh_q[FRAME_W-1 -: SPI_W] : '0;
    assign sclk_o     = shift_i && half_q;
    assign rx_o       = rx_q;

    always_comb begin
        div_d  = div_q;
        half_d = half_q;
        sh_d   = sh_q;
        cnt_d  = cnt_q;
        rx_d   = rx_q;
        if (load_i) begin
            div_d  = '0;
            half_d = 1'b0;
            sh_d   = frame_i;
            cnt_d  = '0;
        end else if (en_i) begin
            div_d = tick_o ? '0 : div_q + DIV_W'(1);
            if (shift_i) begin
                // miso is taken on the first high cycle, while the flash holds it stable
                if (half_q && div_q == '0)
                    rx_d = RX_W'({rx_q, miso_i});
                if (tick_o) begin
                    if (half_q) begin
                        half_d = 1'b0;
                        sh_d   = sh_q << SPI_W;
                        cnt_d  = cnt_q + 8'd1;
                    end else begin
                        half_d = 1'b1;
                    end
                end
            end
        end else begin
            div_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= '0;
            half_q <= 1'b0;
            sh_q   <= '0;
            cnt_q  <= '0;
            rx_q   <= '0;
        end else begin
            div_q  <= div_d;
            half_q <= half_d;
            sh_q   <= sh_d;
            cnt_q  <= cnt_d;
            rx_q   <= rx_d;
        end
    end
endmodule

// File: rtl/apb_spi_flash_ctrl.sv
// APB slave that turns each access into one SPI flash program/read frame.
// Define APBSPI_FAST_READ_EN to issue fast-read (0x0B) with one dummy byte.
module apb_spi_flash_ctrl
    import apb_spi_pkg::*;
#(
    parameter int DATA_BYTES = 4,
    parameter int ADDR_BYTES = 3,
    parameter int SPI_W      = 8,
    parameter int CLK_DIV    = 2,
    parameter int NUM_CS     = 1
) (
    input  logic              p_clk,
    input  logic              p_reset,
    input  logic [APB_DW-1:0] p_addr,
    input  logic              p_write,
    input  logic              p_sel_x,
    input  logic              p_enable,
    input  logic [APB_DW-1:0] p_wdata,
    output logic [APB_DW-1:0] p_rdata,
    output logic              p_ready,
    output logic              p_slverr,
    output logic [SPI_W-1:0]  s_mosi,
    input  logic [SPI_W-1:0]  s_miso,
    output logic              s_clk,
    output logic [NUM_CS-1:0] s_css,
    output logic [2:0]        dbg_state
);
    localparam int SPB = 8 / SPI_W;
    localparam int AW  = ADDR_BYTES * 8;
    localparam int DW  = DATA_BYTES * 8;
`ifdef APBSPI_FAST_READ_EN
    localparam int         DUMMY_BYTES = 1;
    localparam logic [7:0] CMD_RD      = CMD_FAST_READ;
`else
    localparam int         DUMMY_BYTES = 0;
    localparam logic [7:0] CMD_RD      = CMD_READ;
`endif
    localparam int         FRAME_W   = 8 * (1 + ADDR_BYTES + DUMMY_BYTES + DATA_BYTES);
    localparam logic [7:0] END_CMD   = 8'(SPB);
    localparam logic [7:0] END_ADDR  = 8'((1 + ADDR_BYTES) * SPB);
    localparam logic [7:0] END_DUMMY = 8'((1 + ADDR_BYTES + DUMMY_BYTES) * SPB);
    localparam logic [7:0] SYM_WR    = 8'((1 + ADDR_BYTES + DATA_BYTES) * SPB);
    localparam logic [7:0] SYM_RD    = 8'((1 + ADDR_BYTES + DUMMY_BYTES + DATA_BYTES) * SPB);

    state_e            state_q, state_d;
    logic [1:0]        cs_q, cs_d;
    logic              wr_q, wr_d, err_q, err_d, abort_q, abort_d;
    logic [APB_DW-1:0] rdata_q, rdata_d;

    logic               load, active, shift, tick, sym_done, cs_bad, sclk;
    logic [7:0]         cnt, nxt_cnt;
    logic [FRAME_W-1:0] frame;
    logic [DW-1:0]      rx;
    logic [SPI_W-1:0]   mosi;
    logic               unused_bits;

    // Frames are left-aligned so the shifter always starts at the MSB; reads carry zeros after the address.
    always_comb begin
        if (p_write)
            frame = FRAME_W'({CMD_PROG, p_addr[AW-1:0], p_wdata[DW-1:0]}) << (8 * DUMMY_BYTES);
        else
            frame = FRAME_W'({CMD_RD, p_addr[AW-1:0]}) << (FRAME_W - 8 - AW);
    end

    assign cs_bad      = {1'b0, p_addr[31:30]} >= 3'(NUM_CS);
    assign active      = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign shift       = (state_q == ST_CMD) || (state_q == ST_ADDR) ||
                         (state_q == ST_DUMMY) || (state_q == ST_DATA);
    assign nxt_cnt     = cnt + 8'd1;
    assign unused_bits = ^{p_addr, p_wdata};

    spi_shifter #(
        .FRAME_W (FRAME_W),
        .SPI_W   (SPI_W),
        .CLK_DIV (CLK_DIV),
        .RX_W    (DW)
    ) u_shifter (
        .clk        (p_clk),
        .rst        (p_reset),
        .load_i     (load),
        .en_i       (active),
        .shift_i    (shift),
        .frame_i    (frame),
        .miso_i     (s_miso),
        .tick_o     (tick),
        .sym_done_o (sym_done),
        .cnt_o      (cnt),
        .mosi_o     (mosi),
        .sclk_o     (sclk),
        .rx_o       (rx)
    );

    // APB: an access is accepted when p_sel_x && p_enable in IDLE; p_ready is a single-cycle DONE pulse.
    always_comb begin
        state_d = state_q;
        cs_d    = cs_q;
        wr_d    = wr_q;
        err_d   = err_q;
        abort_d = abort_q;
        rdata_d = rdata_q;
        load    = 1'b0;
        if (active && !p_sel_x)
            abort_d = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (p_sel_x && p_enable) begin
                    cs_d    = p_addr[31:30];
                    wr_d    = p_write;
                    abort_d = 1'b0;
                    if (cs_bad) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        err_d   = 1'b0;
                        load    = 1'b1;
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_SETUP: if (tick) state_d = ST_CMD;
            ST_CMD:   if (sym_done && nxt_cnt == END_CMD) state_d = ST_ADDR;
            ST_ADDR: begin
                if (sym_done && nxt_cnt == END_ADDR)
                    state_d = (!wr_q && DUMMY_BYTES != 0) ? ST_DUMMY : ST_DATA;
            end
            ST_DUMMY: if (sym_done && nxt_cnt == END_DUMMY) state_d = ST_DATA;
            ST_DATA: begin
                if (sym_done && nxt_cnt == (wr_q ? SYM_WR : SYM_RD))
                    state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (tick) begin
                    state_d = ST_DONE;
                    if (!wr_q && !abort_d)
                        rdata_d = APB_DW'(rx);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge p_clk) begin
        if (p_reset) begin
            state_q <= ST_IDLE;
            cs_q    <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cs_q    <= cs_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            abort_q <= abort_d;
            rdata_q <= rdata_d;
        end
    end

    assign p_ready   = (state_q == ST_DONE);
    assign p_slverr  = p_ready && err_q;
    assign p_rdata   = rdata_q;
    assign s_mosi    = mosi;
    assign s_clk     = sclk;
    assign s_css     = active ? ~(NUM_CS'(1) << cs_q) : '1;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_apb_spi_flash_ctrl.sv
// Directed bench: default-parameter DUT (A) with byte-lane flash model, plus a 1-bit lane DUT (B).
module tb_apb_spi_flash_ctrl;
`ifdef APBSPI_FAST_READ_EN
  localparam int A_LAT_RD = 41;
  localparam int A_RD_N   = 9;
  localparam logic [127:0] A_RD0_FRAME   = 128'h0B_000000_00_00000000;
  localparam logic [127:0] A_RD100_FRAME = 128'h0B_000100_00_00000000;
  localparam int B_LAT = 197;
  localparam int B_N   = 48;
  localparam int B_HDR = 40;
  localparam logic [127:0] B_FRAME = 128'h0B_000010_00_00;
`else
  localparam int A_LAT_RD = 37;
  localparam int A_RD_N   = 8;
  localparam logic [127:0] A_RD0_FRAME   = 128'h01_000000_00000000;
  localparam logic [127:0] A_RD100_FRAME = 128'h01_000100_00000000;
  localparam int B_LAT = 165;
  localparam int B_N   = 40;
  localparam int B_HDR = 32;
  localparam logic [127:0] B_FRAME = 128'h01_000010_00;
`endif

  // clock/reset and shared APB inputs
  logic p_clk = 1'b0;
  logic p_reset = 1'b1;
  logic [31:0] p_addr = '0, p_wdata = '0;
  logic p_write = 1'b0, p_enable = 1'b0, a_sel = 1'b0, b_sel = 1'b0;
  always #5 p_clk = ~p_clk;

  logic [31:0] a_rdata, b_rdata;
  logic a_ready, a_slverr, a_sclk, b_ready, b_slverr, b_sclk;
  logic [7:0] a_mosi;
  logic [7:0] a_miso = '0;
  logic [0:0] b_mosi;
  logic [0:0] b_miso = '0;
  logic [0:0] a_css, b_css;
  logic [2:0] a_state, b_state;

  apb_spi_flash_ctrl u_dut_a (
    .p_clk(p_clk), .p_reset(p_reset), .p_addr(p_addr), .p_write(p_write),
    .p_sel_x(a_sel), .p_enable(p_enable), .p_wdata(p_wdata), .p_rdata(a_rdata),
    .p_ready(a_ready), .p_slverr(a_slverr), .s_mosi(a_mosi), .s_miso(a_miso),
    .s_clk(a_sclk), .s_css(a_css), .dbg_state(a_state)
  );

  apb_spi_flash_ctrl #(.DATA_BYTES(1), .SPI_W(1)) u_dut_b (
    .p_clk(p_clk), .p_reset(p_reset), .p_addr(p_addr), .p_write(p_write),
    .p_sel_x(b_sel), .p_enable(p_enable), .p_wdata(p_wdata), .p_rdata(b_rdata),
    .p_ready(b_ready), .p_slverr(b_slverr), .s_mosi(b_mosi), .s_miso(b_miso),
    .s_clk(b_sclk), .s_css(b_css), .dbg_state(b_state)
  );

  // flash model A: byte lanes, memory written by program frames, read data driven on falling s_clk
  bit [7:0] a_mem [0:1023];
  bit [7:0] a_q[$];
  logic [127:0] a_last = '0;
  int a_last_n = 0;
  int a_hdr;
  int a_css_low = 0;

  always @(posedge a_sclk) a_q.push_back(a_mosi);
  always @(negedge a_sclk) begin
    if (a_q.size() >= 4 && (a_q[0] == 8'h01 || a_q[0] == 8'h0B)) begin
      a_hdr = (a_q[0] == 8'h0B) ? 5 : 4;
      if (a_q.size() >= a_hdr)
        a_miso = a_mem[10'(int'({a_q[1], a_q[2], a_q[3]}) + a_q.size() - a_hdr)];
    end
  end
  always @(posedge a_css[0]) begin
    if (a_q.size() > 4 && a_q[0] == 8'h02)
      for (int i = 4; i < a_q.size(); i++)
        a_mem[10'(int'({a_q[1], a_q[2], a_q[3]}) + i - 4)] = a_q[i];
    a_last_n = a_q.size();
    a_last = '0;
    foreach (a_q[i]) a_last = {a_last[119:0], a_q[i]};
    a_q.delete();
  end
  always @(negedge p_clk) if (a_css[0] === 1'b0) a_css_low++;

  // flash model B: single lane, always answers 0xA5 after the header
  bit b_q[$];
  logic [127:0] b_last = '0;
  int b_last_n = 0;
  logic [7:0] b_resp = 8'hA5;

  always @(posedge b_sclk) b_q.push_back(b_mosi[0]);
  always @(negedge b_sclk) begin
    if (b_q.size() >= B_HDR && b_q.size() < B_HDR + 8)
      b_miso[0] = b_resp[7 - (b_q.size() - B_HDR)];
  end
  always @(posedge b_css[0]) begin
    b_last_n = b_q.size();
    b_last = '0;
    foreach (b_q[i]) b_last = {b_last[126:0], b_q[i]};
    b_q.delete();
  end

  // scoreboard
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver: APB setup + access phase, then wait (bounded) for p_ready; lat counts cycles from the start edge
  task automatic xfer(input bit inst, input logic [31:0] addr, input bit wr,
                      input logic [31:0] wdata, input int drop_at,
                      output int lat, output logic [31:0] rdata, output logic err);
    @(negedge p_clk);
    p_addr = addr; p_write = wr; p_wdata = wdata; p_enable = 1'b0;
    if (inst) b_sel = 1'b1; else a_sel = 1'b1;
    @(negedge p_clk);
    p_enable = 1'b1;
    lat = 0; rdata = 'x; err = 1'bx;
    for (int i = 1; i <= 1000; i++) begin
      @(negedge p_clk);
      if (i == drop_at) begin a_sel = 1'b0; b_sel = 1'b0; p_enable = 1'b0; end
      if ((inst ? b_ready : a_ready) === 1'b1) begin
        lat = i;
        rdata = inst ? b_rdata : a_rdata;
        err = inst ? b_slverr : a_slverr;
        break;
      end
    end
    a_sel = 1'b0; b_sel = 1'b0; p_enable = 1'b0;
  endtask

  int lat, css0;
  logic [31:0] rd;
  logic err;

  initial begin
    repeat (3) @(negedge p_clk);
    p_reset = 1'b0;
    @(negedge p_clk);
    check("rst_ready", a_ready, 0);
    check("rst_slverr", a_slverr, 0);
    check("rst_rdata", a_rdata, 0);
    check("rst_css", a_css, 1);
    check("rst_sclk", a_sclk, 0);
    check("rst_mosi", a_mosi, 0);
    check("rst_state", a_state, 0);

    css0 = a_css_low;
    xfer(0, 32'h0000_0000, 1, 32'hFF00_FF00, 0, lat, rd, err);
    check("wr_lat", lat, 37);
    check("wr_slverr", err, 0);
    check("wr_frame", a_last, 128'h02_000000_FF00FF00);
    check("wr_nbytes", a_last_n, 8);
    check("wr_css_low", a_css_low - css0, 36);
    @(negedge p_clk);
    check("ready_one_cycle", a_ready, 0);
    check("back_to_idle", a_state, 0);

    xfer(0, 32'h0000_0000, 0, 32'h0, 0, lat, rd, err);
    check("rd_lat", lat, A_LAT_RD);
    check("rd_rdata", rd, 32'hFF00_FF00);
    check("rd_frame", a_last, A_RD0_FRAME);
    check("rd_nbytes", a_last_n, A_RD_N);

    xfer(0, 32'h0000_0100, 1, 32'h1234_5678, 0, lat, rd, err);
    check("wr2_lat", lat, 37);
    xfer(0, 32'h0000_0100, 0, 32'h0, 0, lat, rd, err);
    check("rd2_rdata", rd, 32'h1234_5678);
    check("rd2_frame", a_last, A_RD100_FRAME);

    css0 = a_css_low;
    xfer(0, 32'hC000_0000, 0, 32'h0, 0, lat, rd, err);
    check("err_lat", lat, 1);
    check("err_slverr", err, 1);
    check("err_css_low", a_css_low - css0, 0);
    check("err_rdata_kept", rd, 32'h1234_5678);

    xfer(0, 32'h0000_0000, 0, 32'h0, 5, lat, rd, err);
    check("abort_lat", lat, A_LAT_RD);
    check("abort_rdata_kept", rd, 32'h1234_5678);

    // reset during symbol 4 of a program frame
    @(negedge p_clk);
    p_addr = 32'h0000_0200; p_write = 1'b1; p_wdata = 32'hDEAD_BEEF; a_sel = 1'b1;
    @(negedge p_clk);
    p_enable = 1'b1;
    repeat (19) @(negedge p_clk);
    p_reset = 1'b1;
    @(negedge p_clk);
    check("midrst_css", a_css, 1);
    check("midrst_sclk", a_sclk, 0);
    check("midrst_state", a_state, 0);
    check("midrst_ready", a_ready, 0);
    check("midrst_rdata", a_rdata, 0);
    check("midrst_partial", a_last_n, 4);
    p_reset = 1'b0; a_sel = 1'b0; p_enable = 1'b0;
    xfer(0, 32'h0000_0000, 0, 32'h0, 0, lat, rd, err);
    check("post_rst_lat", lat, A_LAT_RD);
    check("post_rst_rdata", rd, 32'hFF00_FF00);

    xfer(1, 32'h0000_0010, 0, 32'h0, 0, lat, rd, err);
    check("b_lat", lat, B_LAT);
    check("b_rdata", rd, 32'h0000_00A5);
    check("b_edges", b_last_n, B_N);
    check("b_frame", b_last, B_FRAME);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/apb_spi_flash_ctrl.md
APB_SPI_FLASH_CTRL -- requirements
Module: apb_spi_flash_ctrl

Interface
REQ-001 Parameter DATA_BYTES, 4, data bytes per flash access (1..4).
REQ-002 Parameter ADDR_BYTES, 3, flash address bytes sent (3 or 4).
REQ-003 Parameter SPI_W, 8, SPI lane width in bits (1, 2, 4 or 8).
REQ-004 Parameter CLK_DIV, 2, p_clk cycles per s_clk half-period (>=1).
REQ-005 Parameter NUM_CS, 1, number of chip selects (1..4).
REQ-006 p_clk  in  1  sole clock; all logic on its rising edge.
REQ-007 p_reset  in  1  synchronous, active-high reset.
REQ-008 p_addr  in  32  [ADDR_BYTES*8-1:0] flash byte address; [31:30] chip-select index.
REQ-009 p_write  in  1  1 = program, 0 = read.
REQ-010 p_sel_x / p_enable  in  1 each  APB select / access-phase strobe.
REQ-011 p_wdata  in  32  program data; low DATA_BYTES bytes used.
REQ-012 p_rdata  out  32  read data, zero-extended above DATA_BYTES bytes.
REQ-013 p_ready / p_slverr  out  1 each  APB completion / error.
REQ-014 s_mosi  out  SPI_W;  s_miso  in  SPI_W;  s_clk  out  1;  s_css  out  NUM_CS, active-low.

Function
REQ-015 Transaction SHALL start when p_sel_x&&p_enable while FSM is IDLE.
REQ-016 FSM states: IDLE, SETUP, CMD, ADDR, DUMMY, DATA, HOLD, DONE; DUMMY entered only when REQ-029 applies.
REQ-017 Frame SHALL be command byte, ADDR_BYTES address bytes, DATA_BYTES data bytes, all MSB-first; program cmd 0x02, read cmd 0x01.
REQ-018 Each byte SHALL be 8/SPI_W symbols, most significant symbol first.
REQ-019 SETUP: selected s_css bit low, s_clk low, CLK_DIV cycles.
REQ-020 Per symbol: s_mosi updated at start of CLK_DIV low cycles, then s_clk high CLK_DIV cycles; s_miso sampled on the cycle s_clk rises (SPI mode 0).
REQ-021 HOLD: s_clk low, s_css low, CLK_DIV cycles; then all s_css high.
REQ-022 DONE: p_ready=1 for exactly one cycle, p_rdata valid that cycle; next state IDLE.
REQ-023 Latency from start to p_ready: CLK_DIV*(2+2*S)+1 cycles, S = total symbols; default S=8 gives 37.
REQ-024 s_mosi during read data phase SHALL be all zeros.
REQ-025 p_addr[31:30] >= NUM_CS: no SPI activity, p_ready and p_slverr high for one cycle, next cycle.
REQ-026 p_sel_x dropping mid-transaction: frame SHALL complete; DONE pulse still issued; p_rdata not updated.
REQ-027 New access during DONE SHALL NOT start until IDLE.

Reset
REQ-028 p_reset at any cycle, including mid-frame: next cycle IDLE, s_css all 1, s_clk 0, s_mosi 0, p_ready 0, p_slverr 0, p_rdata 0; no partial-frame completion.

Configuration
REQ-029 APBSPI_FAST_READ_EN defined: read cmd 0x0B followed by one dummy byte (mosi 0, miso ignored), S increases by 8/SPI_W; undefined: cmd 0x01, no DUMMY state.

Structure
REQ-030 Package apb_spi_pkg SHALL hold command codes (0x01, 0x02, 0x0B), FSM state enum, APB width constant 32.
REQ-031 Sub-module spi_shifter SHALL implement divider, symbol shift-out/shift-in and bit counting; FSM stays in top.

Verification
REQ-032 Defaults, program 0xFF00FF00 at addr 0 -> mosi 02 00 00 00 FF 00 FF 00 on 8 rising s_clk, s_css[0] low throughout, p_ready at cycle 37.
REQ-033 Read addr 0 after REQ-032 with flash model -> mosi 01 00 00 00 00 00 00 00, p_rdata=0xFF00FF00 on p_ready.
REQ-034 SPI_W=1, DATA_BYTES=1, read 0x000010, model returns 0xA5 -> 40 s_clk edges, p_rdata=0x000000A5.
REQ-035 p_addr=0xC0000000 with NUM_CS=1 -> p_slverr=1, p_ready=1 next cycle, s_css never low.
REQ-036 p_reset asserted at symbol 4 of program -> s_css high next cycle; following read completes normally.
REQ-037 APBSPI_FAST_READ_EN, default read -> cmd 0x0B, 9 bytes, p_ready at cycle 41.
